// File: rtl/xoro_pkg.sv
// Shared peripheral definitions: register word indices and UART STATUS bit layout.
package xoro_pkg;

  // Register word indices (mem_addr[3:2])
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_DIVISOR = 2'd2;

  // STATUS register bit positions
  localparam int unsigned UART_ST_FULL      = 0;
  localparam int unsigned UART_ST_EMPTY     = 1;
  localparam int unsigned UART_ST_BUSY      = 2;
  localparam int unsigned UART_ST_OVERFLOW  = 3;
  localparam int unsigned UART_ST_COUNT_LSB = 8;
  localparam int unsigned UART_ST_COUNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with separate occupancy counter; shared by the UART transmit and receive paths.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and count are reset, storage is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA FIFO, STATUS and DIVISOR registers, baud shifter.
module uart_tx
  import xoro_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DEFAULT_DIVISOR = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        enable,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        serial_out
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      state_q;
  logic [15:0] timer_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        serial_out_q;

  logic        mem_ready_q;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        overflow_q, overflow_d;
  logic [15:0] divisor_q, divisor_d;

  logic        take, is_write, txdata_wr, bit_end, busy;
  logic [1:0]  reg_sel;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0] status_word;
  logic        unused_ok;

  function automatic logic [15:0] clamp_divisor(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

  assign take      = mem_valid & enable & ~mem_ready_q;
  assign is_write  = |mem_wstrb;
  assign reg_sel   = mem_addr[3:2];
  assign txdata_wr = take & is_write & (reg_sel == UART_TXDATA) & mem_wstrb[0];
  assign bit_end   = (timer_q == 16'd1);
  // The last STOP cycle re-checks the FIFO so consecutive frames abut.
  assign fifo_pop  = ~fifo_empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));
  assign fifo_push = txdata_wr & (~fifo_full | fifo_pop);
  assign busy      = (state_q != S_IDLE) | fifo_pop;

  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign serial_out = serial_out_q;
  assign unused_ok  = ^{mem_wdata[31:16], mem_addr[1:0], mem_wstrb[3:2]};

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (mem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble the STATUS read value from live FIFO/shifter state.
  always_comb begin
    status_word = '0;
    status_word[UART_ST_FULL]     = fifo_full;
    status_word[UART_ST_EMPTY]    = fifo_empty;
    status_word[UART_ST_BUSY]     = busy;
    status_word[UART_ST_OVERFLOW] = overflow_q;
    status_word[UART_ST_COUNT_LSB +: UART_ST_COUNT_W] = UART_ST_COUNT_W'(fifo_count);
  end

  // Register writes, sticky overflow and read-data selection for a taken access.
  always_comb begin
    divisor_d   = divisor_q;
    overflow_d  = overflow_q;
    mem_rdata_d = '0;
    if (txdata_wr & ~fifo_push) overflow_d = 1'b1;
    if (take & is_write) begin
      if ((reg_sel == UART_STATUS) && mem_wstrb[0] && mem_wdata[UART_ST_OVERFLOW])
        overflow_d = 1'b0;
      if ((reg_sel == UART_DIVISOR) && (|mem_wstrb[1:0]))
        divisor_d = clamp_divisor({mem_wstrb[1] ? mem_wdata[15:8] : divisor_q[15:8],
                                   mem_wstrb[0] ? mem_wdata[7:0]  : divisor_q[7:0]});
    end
    if (take & ~is_write) begin
      unique case (reg_sel)
        UART_STATUS:  mem_rdata_d = status_word;
        UART_DIVISOR: mem_rdata_d = {16'h0000, divisor_q};
        default:      mem_rdata_d = '0;
      endcase
    end
  end

  // Bus acknowledge, read data and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      overflow_q  <= 1'b0;
      divisor_q   <= 16'(DEFAULT_DIVISOR);
    end else begin
      mem_ready_q <= take;
      mem_rdata_q <= mem_rdata_d;
      overflow_q  <= overflow_d;
      divisor_q   <= divisor_d;
    end
  end

  // Shifter FSM: START, 8 data bits LSB first, STOP; each bit lasts DIVISOR cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      serial_out_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fifo_pop) begin
            state_q      <= S_START;
            timer_q      <= divisor_q;
            bit_idx_q    <= '0;
            shift_q      <= fifo_rdata;
            serial_out_q <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q      <= S_DATA;
            timer_q      <= divisor_q;
            serial_out_q <= shift_q[0];
            shift_q      <= shift_q >> 1;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer_q <= divisor_q;
            if (bit_idx_q == 3'd7) begin
              state_q      <= S_STOP;
              serial_out_q <= 1'b1;
            end else begin
              bit_idx_q    <= bit_idx_q + 3'd1;
              serial_out_q <= shift_q[0];
              shift_q      <= shift_q >> 1;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              state_q      <= S_START;
              timer_q      <= divisor_q;
              bit_idx_q    <= '0;
              shift_q      <= fifo_rdata;
              serial_out_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: bus register behaviour and serial line waveform against a frame-level model.
module tb_uart_tx;

  localparam int DEPTH   = 8;
  localparam int DEF_DIV = 868;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        enable;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        serial_out;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .FIFO_DEPTH      (DEPTH),
    .DEFAULT_DIVISOR (DEF_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .enable     (enable),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status(input bit full, input bit empty, input bit busy,
                                             input bit ovf, input int count);
    logic [31:0] s;
    s = '0;
    s[0] = full;
    s[1] = empty;
    s[2] = busy;
    s[3] = ovf;
    s[15:8] = count[7:0];
    return s;
  endfunction

  // Expected line level for sample i of a frame carrying byte b at d cycles per bit.
  function automatic logic frame_bit(input logic [7:0] b, input int d, input int i);
    int k;
    k = i / d;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // One bus access, called at a negedge; returns at the negedge of the acknowledge cycle.
  task automatic bus_access(input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata);
    int waited;
    mem_valid = 1'b1;
    enable    = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (mem_ready !== 1'b1 && waited < 8);
    if (mem_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL bus_timeout addr=%0h ready=%b want=1", addr, mem_ready);
    end
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    enable    = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_access(addr, wdata, strb, dummy);
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] rdata);
    bus_access(addr, 32'h0, 4'b0000, rdata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_line got=%b want=1", serial_out); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", mem_ready); end
    total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", mem_rdata); end
    reset = 1'b0;
    @(negedge clk);
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL reset_status got=%h want=%h", rd, 32'h2); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'(DEF_DIV)) begin bad++; $display("FAIL reset_divisor got=%0d want=%0d", rd, DEF_DIV); end
  endtask

  // Held request: acknowledged on alternate cycles; deselected window never acknowledges.
  task automatic test_access();
    logic [31:0] rd;
    logic        exp_rdy [3] = '{1'b1, 1'b0, 1'b1};
    @(negedge clk);
    mem_valid = 1'b1; enable = 1'b1; mem_addr = 4'h8; mem_wstrb = 4'b0000; mem_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_ready !== exp_rdy[i] || mem_rdata !== (exp_rdy[i] ? 32'(DEF_DIV) : 32'h0)) begin
        bad++;
        $display("FAIL held_access[%0d] ready=%b rdata=%h want ready=%b", i, mem_ready, mem_rdata, exp_rdy[i]);
      end
    end
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL deselected_ready got=%b want=0", mem_ready); end
    end
    mem_valid = 1'b0;
    @(negedge clk);
    bus_write(4'hC, $urandom, 4'b1111);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reg_c_read got=%h want=0", rd); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h want=0", rd); end
  endtask

  task automatic test_divisor();
    logic [31:0] rd, v;
    logic [15:0] model;
    logic [1:0]  s;
    bus_write(4'h8, 32'h0, 4'b0011);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL div_clamp got=%h want=2", rd); end
    bus_write(4'h8, 32'h1234, 4'b0010);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h1202) begin bad++; $display("FAIL div_hi_strobe got=%h want=1202", rd); end
    model = 16'h1202;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      if (i == 0) v[15:0] = 16'h0001;
      s = 2'($urandom_range(1, 3));
      if (i == 0) s = 2'b11;
      if (s[0]) model[7:0]  = v[7:0];
      if (s[1]) model[15:8] = v[15:8];
      if (model < 16'd2) model = 16'd2;
      bus_write(4'h8, v, {2'b00, s});
      bus_read(4'h8, rd);
      total++;
      if (rd !== {16'h0, model}) begin bad++; $display("FAIL div_rand[%0d] got=%h want=%h", i, rd, model); end
    end
  endtask

  task automatic test_frame(input logic [7:0] data, input int d);
    logic [31:0] rd;
    logic        e;
    bus_write(4'h8, 32'(d), 4'b0011);
    bus_write(4'h0, {24'h0, data}, 4'b0001);
    total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL frame_pre_start got=%b want=1", serial_out); end
    for (int i = 0; i < 10 * d; i++) begin
      @(negedge clk);
      e = frame_bit(data, d, i);
      total++;
      if (serial_out !== e) begin
        bad++;
        $display("FAIL frame_%h_div%0d sample %0d got=%b want=%b", data, d, i, serial_out, e);
      end
    end
    bus_read(4'h4, rd);
    total++; if (rd !== exp_status(0, 1, 1, 0, 0)) begin bad++; $display("FAIL frame_busy_last got=%h want=%h", rd, exp_status(0, 1, 1, 0, 0)); end
    total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL frame_post_line got=%b want=1", serial_out); end
    bus_read(4'h4, rd);
    total++; if (rd !== exp_status(0, 1, 0, 0, 0)) begin bad++; $display("FAIL frame_busy_fall got=%h want=%h", rd, exp_status(0, 1, 0, 0, 0)); end
  endtask

  task automatic test_single_frame();
    test_frame(8'hA5, 4);
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 3; n++) test_frame(8'($urandom), $urandom_range(2, 6));
  endtask

  task automatic test_back_to_back();
    localparam int D = 8;
    logic [7:0] bytes [3];
    logic [31:0] rd;
    bytes[0] = 8'($urandom);
    bytes[1] = 8'h55;
    bytes[2] = 8'h0F;
    bus_write(4'h8, 32'(D), 4'b0011);
    bus_write(4'h0, {24'h0, bytes[0]}, 4'b0001);
    fork
      begin
        int f, k;
        logic e;
        for (int i = 0; i < 30 * D; i++) begin
          @(negedge clk);
          f = i / (10 * D);
          k = i % (10 * D);
          e = frame_bit(bytes[f], D, k);
          total++;
          if (serial_out !== e) begin
            bad++;
            $display("FAIL b2b_line sample %0d got=%b want=%b", i, serial_out, e);
          end
        end
      end
      begin
        logic [31:0] r;
        bus_write(4'h0, {24'h0, bytes[1]}, 4'b0001);
        bus_write(4'h0, {24'h0, bytes[2]}, 4'b0001);
        repeat (5 * D) @(negedge clk);
        bus_read(4'h4, r);
        total++; if (r !== exp_status(0, 0, 1, 0, 2)) begin bad++; $display("FAIL b2b_count2 got=%h want=%h", r, exp_status(0, 0, 1, 0, 2)); end
        repeat (8 * D) @(negedge clk);
        bus_read(4'h4, r);
        total++; if (r !== exp_status(0, 0, 1, 0, 1)) begin bad++; $display("FAIL b2b_count1 got=%h want=%h", r, exp_status(0, 0, 1, 0, 1)); end
        repeat (10 * D) @(negedge clk);
        bus_read(4'h4, r);
        total++; if (r !== exp_status(0, 1, 1, 0, 0)) begin bad++; $display("FAIL b2b_count0 got=%h want=%h", r, exp_status(0, 1, 1, 0, 0)); end
      end
    join
    @(negedge clk);
    total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL b2b_idle_line got=%b want=1", serial_out); end
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL b2b_final_status got=%h want=2", rd); end
  endtask

  task automatic test_overflow();
    localparam int NW = 10;
    logic [31:0] rd;
    int cnt;
    bit ovf;
    bus_write(4'h8, 32'd100, 4'b0011);
    for (int i = 0; i < NW; i++) bus_write(4'h0, $urandom, 4'b0001);
    // First byte leaves for the shifter at once; the rest queue until DEPTH.
    cnt = (NW - 1 > DEPTH) ? DEPTH : NW - 1;
    ovf = (NW - 1 > DEPTH);
    bus_read(4'h4, rd);
    total++; if (rd !== exp_status(cnt == DEPTH, cnt == 0, 1, ovf, cnt)) begin bad++; $display("FAIL ovf_status got=%h want=%h", rd, exp_status(cnt == DEPTH, cnt == 0, 1, ovf, cnt)); end
    bus_write(4'h4, 32'h8, 4'b0001);
    bus_read(4'h4, rd);
    total++; if (rd !== exp_status(cnt == DEPTH, cnt == 0, 1, 0, cnt)) begin bad++; $display("FAIL ovf_clear got=%h want=%h", rd, exp_status(cnt == DEPTH, cnt == 0, 1, 0, cnt)); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd100) begin bad++; $display("FAIL ovf_divisor_kept got=%0d want=100", rd); end
    do_reset();
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL ovf_after_reset got=%h want=2", rd); end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0]  b;
    logic [31:0] rd;
    bit          saw_low;
    b = 8'($urandom);
    bus_write(4'h8, 32'd4, 4'b0011);
    bus_write(4'h0, {24'h0, b}, 4'b0001);
    bus_write(4'h0, $urandom, 4'b0001);
    // Advance into data bit 3 (frame samples 16..19).
    repeat (16) @(negedge clk);
    total++; if (serial_out !== b[3]) begin bad++; $display("FAIL mid_bit3 got=%b want=%b", serial_out, b[3]); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL mid_reset_line got=%b want=1", serial_out); end
    reset = 1'b0;
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (serial_out !== 1'b1) saw_low = 1'b1;
    end
    total++; if (saw_low !== 1'b0) begin bad++; $display("FAIL mid_reset_quiet got=%b want=0", saw_low); end
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL mid_reset_status got=%h want=2", rd); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'(DEF_DIV)) begin bad++; $display("FAIL mid_reset_divisor got=%0d want=%0d", rd, DEF_DIV); end
  endtask

  initial begin
    reset     = 1'b1;
    mem_valid = 1'b0;
    enable    = 1'b0;
    mem_addr  = 4'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'b0000;
    @(negedge clk);
    test_reset();
    test_access();
    test_divisor();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_overflow();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
